// File: rtl/p2s_rr_sched_if.sv
// Bus bundle for p2s_rr_sched.
//   master : requester/link side (drives req_valid, req_data, ser_ready)
//   slave  : scheduler side (drives req_ready and the serial outputs)
// Channel i word occupies req_data[i*DWIDTH +: DWIDTH].
interface p2s_rr_sched_if #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DWIDTH = 8
);
  localparam int unsigned CW = $clog2(NCH);

  logic [NCH-1:0]        req_valid;
  logic [NCH*DWIDTH-1:0] req_data;
  logic [NCH-1:0]        req_ready;
  logic                  ser_ready;
  logic                  ser_dout;
  logic                  ser_valid;
  logic                  ser_sof;
  logic                  ser_eof;
  logic [CW-1:0]         ser_chan;
  logic                  busy;

  modport master (
    output req_valid, req_data, ser_ready,
    input  req_ready, ser_dout, ser_valid, ser_sof, ser_eof, ser_chan, busy
  );

  modport slave (
    input  req_valid, req_data, ser_ready,
    output req_ready, ser_dout, ser_valid, ser_sof, ser_eof, ser_chan, busy
  );
endinterface

// File: rtl/p2s_rr_sched.sv
// Round-robin arbiter feeding an LSB-first parallel-to-serial shifter.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : slave side of p2s_rr_sched_if
//     req_valid/req_data in, req_ready out (one-hot accept, combinational)
//     ser_ready in; ser_dout/ser_valid/ser_sof/ser_eof/ser_chan/busy out
module p2s_rr_sched #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned DWIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  p2s_rr_sched_if.slave      bus
);
  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned BW = $clog2(DWIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [CW-1:0]     ptr_q, ptr_d;

  logic [CW-1:0]     grant_c;
  logic              any_c;
  logic              last_c;
  logic              win_c;
  logic              accept_c;
  int unsigned       idx;

  // Rotating priority search starting at the pointer; NCH need not be 2^n,
  // so the wrap is an explicit subtract rather than a bit truncation.
  always_comb begin
    grant_c = '0;
    any_c   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_c && bus.req_valid[idx]) begin
        any_c   = 1'b1;
        grant_c = CW'(idx);
      end
    end
  end

  // Accept while idle, or on the final bit of a word when it is consumed,
  // so back-to-back words leave no gap on the link.
  assign last_c   = (state_q == SHIFT) && (bitcnt_q == LAST_BIT);
  assign win_c    = (state_q == IDLE) || (last_c && bus.ser_ready);
  assign accept_c = win_c && any_c;

  assign bus.req_ready = accept_c ? (NCH'(1) << grant_c) : '0;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    chan_d   = chan_q;
    ptr_d    = ptr_q;

    case (state_q)
      IDLE: ;
      SHIFT: begin
        if (bus.ser_ready) begin
          if (bitcnt_q != LAST_BIT) begin
            shift_d  = shift_q >> 1;
            bitcnt_d = bitcnt_q + BW'(1);
          end else begin
            state_d  = IDLE;
            shift_d  = '0;
            bitcnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides the return to IDLE on the last-bit edge.
    if (accept_c) begin
      state_d  = SHIFT;
      shift_d  = bus.req_data[32'(grant_c)*DWIDTH +: DWIDTH];
      bitcnt_d = '0;
      chan_d   = grant_c;
      ptr_d    = (grant_c == LAST_CH) ? '0 : grant_c + CW'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      chan_q   <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      chan_q   <= chan_d;
      ptr_q    <= ptr_d;
    end
  end

  // Serial outputs are pure decodes of the registered state.
  assign bus.ser_valid = (state_q == SHIFT);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.ser_dout  = (state_q == SHIFT) && shift_q[0];
  assign bus.ser_sof   = (state_q == SHIFT) && (bitcnt_q == '0);
  assign bus.ser_eof   = last_c;
  assign bus.ser_chan  = chan_q;

endmodule

// File: tb/tb_p2s_rr_sched.sv
// Self-checking bench for p2s_rr_sched: queue-based reference model of the
// serial stream plus directed scenarios and a randomized soak.
module tb_p2s_rr_sched;
  localparam int unsigned NCH    = 4;
  localparam int unsigned DWIDTH = 8;

  logic clk;
  logic rstn;

  p2s_rr_sched_if #(.NCH(NCH), .DWIDTH(DWIDTH)) bus ();

  p2s_rr_sched #(.NCH(NCH), .DWIDTH(DWIDTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester / link stimulus state
  logic [NCH-1:0]    v;
  logic [DWIDTH-1:0] d [NCH];
  logic              sr;
  int                refill;    // 0: drop on accept, 1: re-offer same word, 2: random
  bit                rand_arr;
  bit                sr_rand;
  int                stall_at;
  int                stall_n;

  // Reference model: remaining bits of the word in flight, LSB first
  bit mq[$];
  int mchan;
  int mptr;
  int cyc;
  int load_cyc;
  int last_cyc;
  int acc_ch;
  int grant_log[$];
  int gcyc_log[$];
  bit bit_log[$];

  int n_checks;
  int n_fails;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (mptr + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    mchan = 0;
    mptr  = 0;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    gcyc_log.delete();
    bit_log.delete();
  endtask

  // One clock edge of the model, using the inputs presented before the edge.
  task automatic model_step();
    int g;
    bit win;
    cyc++;
    acc_ch = -1;
    g   = m_grant();
    win = (mq.size() == 0) || (mq.size() == 1 && sr);
    if (mq.size() > 0 && sr) begin
      bit_log.push_back(mq.pop_front());
      if (mq.size() == 0) last_cyc = cyc;
    end
    if (win && g >= 0) begin
      mq.delete();
      for (int b = 0; b < DWIDTH; b++) mq.push_back(d[g][b]);
      mchan = g;
      mptr  = (g + 1) % NCH;
      grant_log.push_back(g);
      gcyc_log.push_back(cyc);
      load_cyc = cyc;
      acc_ch   = g;
    end
  endtask

  task automatic apply();
    bus.req_valid = v;
    for (int i = 0; i < NCH; i++) bus.req_data[i*DWIDTH +: DWIDTH] = d[i];
    bus.ser_ready = sr;
  endtask

  task automatic check_outputs();
    int g;
    bit act;
    bit win;
    logic [NCH-1:0] er;
    g   = m_grant();
    act = (mq.size() > 0);
    win = !act || (mq.size() == 1 && sr);
    er  = '0;
    if (win && g >= 0) er[g] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("ser_valid", 32'(bus.ser_valid), 32'(act));
    chk("busy",      32'(bus.busy),      32'(act));
    chk("ser_dout",  32'(bus.ser_dout),  act ? 32'(mq[0]) : 32'd0);
    chk("ser_sof",   32'(bus.ser_sof),   32'(act && mq.size() == DWIDTH));
    chk("ser_eof",   32'(bus.ser_eof),   32'(act && mq.size() == 1));
    chk("ser_chan",  32'(bus.ser_chan),  32'(mchan));
  endtask

  // Advance one cycle: model edge, react to accepts, drive, compare mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    else acc_ch = -1;
    #2;
    if (acc_ch >= 0) begin
      case (refill)
        0: v[acc_ch] = 1'b0;
        1: ;
        default: begin
          if ($urandom_range(1) == 0) v[acc_ch] = 1'b0;
          else d[acc_ch] = DWIDTH'($urandom);
        end
      endcase
    end
    if (rand_arr) begin
      for (int i = 0; i < NCH; i++) begin
        if (!v[i] && $urandom_range(3) == 0) begin
          v[i] = 1'b1;
          d[i] = DWIDTH'($urandom);
        end
      end
    end
    sr = sr_rand ? ($urandom_range(3) != 0) : 1'b1;
    if (stall_n > 0 && mq.size() > 0 && (DWIDTH - mq.size()) == stall_at) begin
      sr = 1'b0;
      stall_n--;
    end
    apply();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    v    = '0;
    apply();
    model_reset();
    #1;
    check_outputs();
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((mq.size() > 0 || v != '0) && n < max) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= max) begin
      n_fails++;
      $display("FAIL wait_idle timeout after %0d cycles (still busy, expected idle)", n);
    end
  endtask

  task automatic wait_pos(input int pos, input int max);
    int n;
    n = 0;
    while (!(mq.size() > 0 && (DWIDTH - mq.size()) == pos) && n < max) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= max) begin
      n_fails++;
      $display("FAIL wait_pos timeout waiting for bit %0d (got none, expected reach)", pos);
    end
  endtask

  initial begin
    bit lit_a5 [8];
    int ones;
    int rr_exp [5];

    n_checks = 0;
    n_fails  = 0;
    cyc      = 0;
    load_cyc = 0;
    last_cyc = 0;
    acc_ch   = -1;
    refill   = 0;
    rand_arr = 1'b0;
    sr_rand  = 1'b0;
    stall_at = 0;
    stall_n  = 0;
    sr       = 1'b1;
    v        = '0;
    for (int i = 0; i < NCH; i++) d[i] = '0;
    rstn = 1'b1;
    apply();
    #3;
    do_reset();

    // Single word 0xA5 on channel 2
    clear_logs();
    v[2] = 1'b1; d[2] = 8'hA5; apply();
    wait_idle(30);
    lit_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    chk("t1_ngrants", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() >= 1) chk("t1_chan", 32'(grant_log[0]), 32'd2);
    chk("t1_nbits", 32'(bit_log.size()), 32'd8);
    for (int b = 0; b < 8 && b < bit_log.size(); b++) chk("t1_bit", 32'(bit_log[b]), 32'(lit_a5[b]));
    chk("t1_len", 32'(last_cyc - load_cyc), 32'd8);

    // Round robin with all channels continuously valid
    do_reset();
    clear_logs();
    refill = 1;
    v = 4'hF; d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44; apply();
    repeat (36) tick();
    rr_exp = '{0, 1, 2, 3, 0};
    chk("t2_ngrants", 32'(grant_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("t2_order", 32'(grant_log[k]), 32'(rr_exp[k]));
    for (int k = 1; k < 5 && k < gcyc_log.size(); k++) chk("t2_spacing", 32'(gcyc_log[k] - gcyc_log[k-1]), 32'd8);
    refill = 0;
    wait_idle(60);

    // Backpressure: 3-cycle stall at bit 4
    do_reset();
    clear_logs();
    v[0] = 1'b1; d[0] = 8'hFF; stall_at = 4; stall_n = 3; apply();
    wait_idle(40);
    ones = 0;
    foreach (bit_log[b]) ones += int'(bit_log[b]);
    chk("t3_nbits", 32'(bit_log.size()), 32'd8);
    chk("t3_ones", 32'(ones), 32'd8);
    chk("t3_len", 32'(last_cyc - load_cyc), 32'd11);

    // Pointer skip: pointer at 1, channels 3 and 0 pending
    do_reset();
    v[0] = 1'b1; d[0] = 8'h3C; apply();
    wait_idle(30);
    clear_logs();
    v[3] = 1'b1; d[3] = 8'h96; v[0] = 1'b1; d[0] = 8'h69; apply();
    wait_idle(40);
    chk("t4_ngrants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      chk("t4_first", 32'(grant_log[0]), 32'd3);
      chk("t4_second", 32'(grant_log[1]), 32'd0);
    end
    chk("t4_ptr", 32'(mptr), 32'd1);

    // Request arriving while the last bit is stalled
    do_reset();
    clear_logs();
    v[0] = 1'b1; d[0] = 8'h5A; stall_at = 7; stall_n = 2; apply();
    wait_pos(7, 20);
    v[1] = 1'b1; d[1] = 8'hC3; apply();
    wait_idle(40);
    chk("t5_ngrants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      chk("t5_second", 32'(grant_log[1]), 32'd1);
      chk("t5_gap", 32'(gcyc_log[1] - gcyc_log[0]), 32'd10);
    end

    // Reset in the middle of a word
    do_reset();
    v[2] = 1'b1; d[2] = 8'hE7; apply();
    wait_idle(30);
    v[1] = 1'b1; d[1] = 8'h81; apply();
    wait_pos(3, 20);
    do_reset();
    clear_logs();
    v[0] = 1'b1; d[0] = 8'h01; v[1] = 1'b1; d[1] = 8'h02; apply();
    wait_idle(40);
    chk("t6_ngrants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      chk("t6_first", 32'(grant_log[0]), 32'd0);
      chk("t6_second", 32'(grant_log[1]), 32'd1);
    end

    // Randomized soak with backpressure and occasional resets
    do_reset();
    refill   = 2;
    rand_arr = 1'b1;
    sr_rand  = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(499) == 0) do_reset();
    end
    refill   = 0;
    rand_arr = 1'b0;
    sr_rand  = 1'b0;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/p2s_rr_sched.md
Name: p2s_rr_sched

Overview:
Multi-channel front end for a serialiser. It arbitrates NCH parallel requesters round-robin and loads the granted word into an internal shift register. The word is shifted out LSB-first with frame markers, under downstream backpressure. It sits between the per-channel word producers and the single-bit serial link.

Parameters:
NCH, 4, number of requesting channels (>=2, need not be a power of two)
DWIDTH, 8, word width in bits (>=2)
CW, $clog2(NCH), channel-id width (derived, localparam)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  NCH  per-channel word available
req_data  in  NCH*DWIDTH  channel i word at bits [i*DWIDTH +: DWIDTH]
req_ready  out  NCH  one-hot grant/accept; the word is taken at an edge where req_valid[i]&req_ready[i]
ser_ready  in  1  downstream accepts the current bit this cycle
ser_dout  out  1  serial data bit
ser_valid  out  1  ser_dout is meaningful
ser_sof  out  1  first bit of a word
ser_eof  out  1  last bit of a word
ser_chan  out  CW  channel id of the word being shifted
busy  out  1  a word is in flight

Behaviour:
- Reset (async assert, sync-to-clk deassert by environment): state IDLE, shift reg 0, bitcnt 0, rr pointer 0.
- Reset output values: req_ready=0, ser_valid=0, ser_dout=0, ser_sof=0, ser_eof=0, ser_chan=0, busy=0.
- FSM has two states: IDLE, SHIFT.
- Grant (combinational): first i with req_valid[i]=1, searching pointer, pointer+1, ... wrapping modulo NCH.
- req_ready is one-hot or zero. It may depend on req_valid and ser_ready. It never has a combinational path from req_data.
- Accept window: req_ready[grant]=1 when state==IDLE, or when state==SHIFT & bitcnt==DWIDTH-1 & ser_ready (back-to-back).
- On accept:
  - shift reg <= req_data[grant]
  - ser_chan <= grant
  - bitcnt <= 0
  - pointer <= (grant+1) mod NCH
  - state <= SHIFT
- Pointer changes only on accept.
- SHIFT outputs:
  - ser_valid=1, busy=1, ser_dout=shift[0]
  - ser_sof=(bitcnt==0), ser_eof=(bitcnt==DWIDTH-1)
- Advance (ser_ready=1 in SHIFT), if bitcnt<DWIDTH-1: shift right, zero fill; bitcnt+1.
- Last bit (bitcnt==DWIDTH-1) with ser_ready: go to IDLE if no accept. With an accept, the new word loads in the same edge, so there are no idle cycles between words.
- Stall (ser_ready=0): shift reg, bitcnt, ser_chan and all ser_* outputs hold. No accept occurs.
- IDLE outputs: ser_valid=0, ser_sof=0, ser_eof=0, ser_dout=0, busy=0. ser_chan holds its last value. The first accept from IDLE loads on the edge where req_valid is seen, so the word's first bit appears the next cycle (latency 1).
- Requester rules:
  - Once req_valid[i] is asserted, it and req_data for channel i stay stable until accepted.
  - Deassertion without accept is a protocol violation; the block still never grants an invalid channel.
- Fairness: with all channels continuously valid, grants cycle 0,1,...,NCH-1,0. No channel waits more than NCH-1 words.
- Reset mid-word: the word is dropped without ser_eof; output returns to reset values immediately.
- Bitcnt width: $clog2(DWIDTH) bits, compared against DWIDTH-1 only. It never wraps past DWIDTH-1.

Test Plan:
- Single word: NCH=4, DWIDTH=8, ch2 sends 0xA5, ser_ready=1 → ser_chan=2; bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; sof on bit0 only; eof on bit7 only; then IDLE.
- Round robin: all four valid continuously with words 0x11,0x22,0x33,0x44 → grants in order 0,1,2,3,0. Exactly 8 ser_valid cycles per word, no gaps. req_ready pulses exactly on each eof cycle.
- Backpressure: ch0 sends 0xFF, ser_ready low for 3 cycles at bit 4 → bits 4 and bitcnt hold during the stall; 8 bits still delivered; eof occurs 3 cycles later than unstalled.
- Pointer skip: pointer=1, only ch3 and ch0 valid → ch3 granted first, then ch0. Pointer ends at 1.
- Eof-edge accept with stall: ch1 valid while bit7 stalls → req_ready stays 0 until ser_ready=1. Then load happens on the same edge, and the next cycle shows sof with ser_chan=1.
- Reset mid-frame: assert rstn low at bit 3 of a word → all outputs 0 within the reset cycle, pointer 0. After release, ch0 is granted before ch1.
